// File: rtl/sdcard_crc_monitor.sv
// sdcard_crc_monitor: snoops the SD-card DMA byte stream and computes the SD data-block
// CRC16 (poly 0x1021, init 0, MSB first) over each BLOCK_LEN-byte block. It exposes the
// CRC, byte count, block count and status through an 8-register window on the AVR SRAM bus.
// Latency: one strobe updates the CRC, count and state on its sampling edge, and a read
// sees the change on the next cycle. Reads stall for one wait cycle; writes never stall.
// Backpressure: none on the DMA side (back-to-back strobes are absorbed); sram_wait=1 only
// during the first cycle of each read access.
//
// Ports:
//   clk, rst                       clkout-domain clock, synchronous active-high reset
//   dma_data, dma_addr, dma_strobe snooped DMA byte, its block offset, one-cycle valid pulse
//   sram_a[2:0]                    register select (upper bits not decoded)
//   sram_d_in, sram_d_out          AVR write / read data
//   sram_cs, sram_oe, sram_we      window select, read enable, write enable
//   sram_wait                      read stall, high for the first cycle of a read
module sdcard_crc_monitor #(
  parameter int BLOCK_LEN = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  dma_data,
  input  logic [8:0]  dma_addr,
  input  logic        dma_strobe,
  input  logic [15:0] sram_a,
  input  logic [7:0]  sram_d_in,
  output logic [7:0]  sram_d_out,
  input  logic        sram_cs,
  input  logic        sram_oe,
  input  logic        sram_we,
  output logic        sram_wait
);

  localparam logic [8:0] LAST_ADDR = 9'(BLOCK_LEN - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        en_q, en_d;
  logic        done_q, done_d;
  logic        addr_err_q, addr_err_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] crc_latch_q, crc_latch_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [7:0]  blocks_q, blocks_d;

  logic        ctrl_wr;
  logic        clear;
  logic        start;
  logic        in_seq;
  logic [15:0] crc_upd;

  logic        rd_ready_q;
  logic        rd_req;
  logic [7:0]  rd_data;

  // Only the low three address bits select a register.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^sram_a[15:3];

  // One byte through the CRC16 shift register, MSB first, in a single cycle.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  assign ctrl_wr = sram_cs & sram_we & (sram_a[2:0] == 3'd0);
  assign clear   = ctrl_wr & sram_d_in[0];

  // Next-state and datapath. A CLEAR in the same cycle as a strobe takes
  // priority, so that byte is dropped.
  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    done_d      = done_q;
    addr_err_d  = addr_err_q;
    crc_d       = crc_q;
    crc_latch_d = crc_latch_q;
    cnt_d       = cnt_q;
    blocks_d    = blocks_q;
    start       = (dma_addr == 9'd0);
    in_seq      = (state_q == ACTIVE) && ({1'b0, dma_addr} == cnt_q);
    crc_upd     = crc16_byte(start ? 16'h0000 : crc_q, dma_data);

    if (ctrl_wr) begin
      en_d = sram_d_in[1];
    end

    if (clear) begin
      state_d     = IDLE;
      done_d      = 1'b0;
      addr_err_d  = 1'b0;
      crc_d       = 16'h0000;
      crc_latch_d = 16'h0000;
      cnt_d       = 10'd0;
      blocks_d    = 8'd0;
    end else if (dma_strobe && en_q) begin
      if (start || in_seq) begin
        crc_d = crc_upd;
        cnt_d = start ? 10'd1 : cnt_q + 10'd1;
        // Offset 0 while a block is open aborts it; the new block still starts.
        if (start && (state_q == ACTIVE)) begin
          addr_err_d = 1'b1;
        end
        if (dma_addr == LAST_ADDR) begin
          crc_latch_d = crc_upd;
          done_d      = 1'b1;
          blocks_d    = blocks_q + 8'd1;
          state_d     = IDLE;
        end else begin
          state_d = ACTIVE;
        end
      end else begin
        // Out-of-sequence byte: discarded, count held for firmware inspection.
        addr_err_d = 1'b1;
        state_d    = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      crc_q       <= 16'h0000;
      crc_latch_q <= 16'h0000;
      cnt_q       <= 10'd0;
      blocks_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      done_q      <= done_d;
      addr_err_q  <= addr_err_d;
      crc_q       <= crc_d;
      crc_latch_q <= crc_latch_d;
      cnt_q       <= cnt_d;
      blocks_q    <= blocks_d;
    end
  end

  // Register read mux.
  always_comb begin
    rd_data = 8'h00;
    case (sram_a[2:0])
      3'd0:    rd_data = {4'b0000, en_q, addr_err_q, done_q, state_q == ACTIVE};
      3'd1:    rd_data = crc_latch_q[7:0];
      3'd2:    rd_data = crc_latch_q[15:8];
      3'd3:    rd_data = cnt_q[7:0];
      3'd4:    rd_data = {6'b000000, cnt_q[9:8]};
      3'd5:    rd_data = blocks_q;
      default: rd_data = 8'h00;
    endcase
  end

  // Read handshake: stall the first cycle, register the data on that edge,
  // then hold the ready flag until the window is deselected.
  assign rd_req    = sram_cs & sram_oe;
  assign sram_wait = rd_req & ~rd_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ready_q <= 1'b0;
      sram_d_out <= 8'h00;
    end else if (!sram_cs) begin
      rd_ready_q <= 1'b0;
    end else if (sram_wait) begin
      rd_ready_q <= 1'b1;
      sram_d_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_sdcard_crc_monitor.sv
// Testbench for sdcard_crc_monitor: table-driven block checks, hand-written corner cases,
// and randomized traffic checked against a queue-based reference model.
module tb_sdcard_crc_monitor;

  logic        clk;
  logic        rst;
  logic [7:0]  dma_data;
  logic [8:0]  dma_addr;
  logic        dma_strobe;
  logic [15:0] sram_a;
  logic [7:0]  sram_d_in;
  logic        sram_cs;
  logic        sram_oe;
  logic        sram_we;
  logic [7:0]  d_out;
  logic        wait_o;
  logic [7:0]  d_out9;
  logic        wait9;

  int checks = 0;
  int errors = 0;

  sdcard_crc_monitor #(.BLOCK_LEN(512)) dut (
    .clk(clk), .rst(rst), .dma_data(dma_data), .dma_addr(dma_addr),
    .dma_strobe(dma_strobe), .sram_a(sram_a), .sram_d_in(sram_d_in),
    .sram_d_out(d_out), .sram_cs(sram_cs), .sram_oe(sram_oe),
    .sram_we(sram_we), .sram_wait(wait_o)
  );

  sdcard_crc_monitor #(.BLOCK_LEN(9)) dut9 (
    .clk(clk), .rst(rst), .dma_data(dma_data), .dma_addr(dma_addr),
    .dma_strobe(dma_strobe), .sram_a(sram_a), .sram_d_in(sram_d_in),
    .sram_d_out(d_out9), .sram_cs(sram_cs), .sram_oe(sram_oe),
    .sram_we(sram_we), .sram_wait(wait9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (BLOCK_LEN = 512) ----------------
  bit         m_en, m_busy, m_done, m_err;
  logic [7:0] m_blocks;
  logic [15:0] m_latch;
  logic [7:0] q[$];

  // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
  function automatic logic [15:0] crc_ref(input logic [7:0] msg[$]);
    logic [15:0] r;
    logic        b;
    logic        top;
    int          nbits;
    r = 16'h0000;
    nbits = msg.size() * 8 + 16;
    for (int i = 0; i < nbits; i++) begin
      b   = (i < msg.size() * 8) ? msg[i / 8][7 - (i % 8)] : 1'b0;
      top = r[15];
      r   = {r[14:0], b};
      if (top) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_en = 0; m_busy = 0; m_done = 0; m_err = 0;
    m_blocks = 8'd0; m_latch = 16'h0; q.delete();
  endfunction

  function automatic void model_write(input logic [7:0] d);
    if (d[0]) begin
      q.delete(); m_busy = 0; m_done = 0; m_err = 0;
      m_blocks = 8'd0; m_latch = 16'h0;
    end
    m_en = d[1];
  endfunction

  function automatic void model_strobe(input logic [8:0] a, input logic [7:0] d);
    bit accepted;
    accepted = 0;
    if (!m_en) return;
    if (a == 9'd0) begin
      if (m_busy) m_err = 1;
      q.delete(); q.push_back(d); m_busy = 1; accepted = 1;
    end else if (m_busy && int'(a) == q.size()) begin
      q.push_back(d); accepted = 1;
    end else begin
      m_err = 1; m_busy = 0;
    end
    if (accepted && a == 9'd511) begin
      m_latch = crc_ref(q); m_done = 1; m_blocks = m_blocks + 8'd1; m_busy = 0;
    end
  endfunction

  function automatic logic [7:0] model_reg(input logic [2:0] a);
    logic [9:0] cnt;
    cnt = 10'(q.size());
    case (a)
      3'd0: return {4'b0, m_en, m_err, m_done, m_busy};
      3'd1: return m_latch[7:0];
      3'd2: return m_latch[15:8];
      3'd3: return cnt[7:0];
      3'd4: return {6'b0, cnt[9:8]};
      3'd5: return m_blocks;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- bench tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] v, output logic [7:0] v9);
    int n;
    @(posedge clk); #1;
    dma_strobe = 1'b0; sram_we = 1'b0;
    sram_a = {13'h0, a}; sram_cs = 1'b1; sram_oe = 1'b1;
    n = 0;
    @(negedge clk);
    while (wait_o === 1'b1 && n < 4) begin
      n++;
      @(negedge clk);
    end
    check("read_wait_cycles", n, 1);
    v  = d_out;
    v9 = d_out9;
    @(posedge clk); #1;
    sram_cs = 1'b0; sram_oe = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    @(posedge clk); #1;
    dma_strobe = 1'b0; sram_oe = 1'b0;
    sram_a = 16'h0; sram_d_in = d; sram_cs = 1'b1; sram_we = 1'b1;
    model_write(d);
    @(posedge clk); #1;
    sram_cs = 1'b0; sram_we = 1'b0;
  endtask

  task automatic strobe(input logic [8:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    sram_cs = 1'b0; sram_oe = 1'b0; sram_we = 1'b0;
    dma_strobe = 1'b1; dma_addr = a; dma_data = d;
    model_strobe(a, d);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    dma_strobe = 1'b0;
  endtask

  task automatic stream(input int first, input int last, input logic [7:0] fill, input bit rnd);
    for (int i = first; i <= last; i++)
      strobe(9'(i), rnd ? 8'($urandom) : fill);
    idle();
  endtask

  typedef struct {
    logic [7:0]  fill;
    logic [15:0] crc;
    logic [7:0]  blocks;
    logic [7:0]  status;
  } vec_t;

  vec_t       vecs[3];
  logic [7:0] v, v9, lo, hi;
  string      digits;

  initial begin
    vecs[0] = '{fill: 8'hFF, crc: 16'h7FA1, blocks: 8'd1, status: 8'h0A};
    vecs[1] = '{fill: 8'h00, crc: 16'h0000, blocks: 8'd2, status: 8'h0A};
    vecs[2] = '{fill: 8'hFF, crc: 16'h7FA1, blocks: 8'd3, status: 8'h0A};
    digits  = "123456789";

    rst = 1'b1; dma_data = 8'h0; dma_addr = 9'h0; dma_strobe = 1'b0;
    sram_a = 16'h0; sram_d_in = 8'h0; sram_cs = 1'b0; sram_oe = 1'b0; sram_we = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_d_out", d_out, 8'h00);
    check("reset_wait", wait_o, 1'b0);
    rd(3'd0, v, v9); check("reset_status", v, 8'h00);
    rd(3'd5, v, v9); check("reset_blocks", v, 8'h00);

    // Table-driven full blocks
    wr(8'h02);
    for (int k = 0; k < 3; k++) begin
      stream(0, 511, vecs[k].fill, 1'b0);
      rd(3'd1, lo, v9);
      rd(3'd2, hi, v9);
      check($sformatf("vec%0d_crc", k), {hi, lo}, vecs[k].crc);
      rd(3'd0, v, v9); check($sformatf("vec%0d_status", k), v, vecs[k].status);
      rd(3'd5, v, v9); check($sformatf("vec%0d_blocks", k), v, vecs[k].blocks);
      rd(3'd3, v, v9); check($sformatf("vec%0d_cnt_lo", k), v, 8'h00);
      rd(3'd4, v, v9); check($sformatf("vec%0d_cnt_hi", k), v, 8'h02);
    end

    // Out-of-sequence address mid-block
    wr(8'h03);
    stream(0, 99, 8'h00, 1'b1);
    strobe(9'd150, 8'h5A); idle();
    rd(3'd0, v, v9); check("skip_status", v, 8'h0C);
    rd(3'd3, v, v9); check("skip_cnt_lo", v, 8'd100);
    rd(3'd4, v, v9); check("skip_cnt_hi", v, 8'd0);
    rd(3'd5, v, v9); check("skip_blocks", v, 8'd0);
    wr(8'h03);
    rd(3'd0, v, v9); check("clear_status", v, 8'h08);
    rd(3'd3, v, v9); check("clear_cnt", v, 8'd0);

    // Restart at offset 0 inside an open block
    stream(0, 9, 8'h00, 1'b1);
    strobe(9'd0, 8'h11); idle();
    rd(3'd0, v, v9); check("abort_status", v, 8'h0D);
    rd(3'd3, v, v9); check("abort_cnt", v, 8'd1);

    // Disabled: strobes ignored
    wr(8'h01);
    stream(0, 511, 8'hAA, 1'b0);
    rd(3'd3, v, v9); check("dis_cnt_lo", v, 8'd0);
    rd(3'd4, v, v9); check("dis_cnt_hi", v, 8'd0);
    rd(3'd5, v, v9); check("dis_blocks", v, 8'd0);
    rd(3'd0, v, v9); check("dis_status", v, 8'h00);

    // CLEAR and strobe in the same cycle: CLEAR wins
    wr(8'h02);
    stream(0, 4, 8'h00, 1'b1);
    @(posedge clk); #1;
    sram_a = 16'h0; sram_d_in = 8'h03; sram_cs = 1'b1; sram_we = 1'b1;
    dma_strobe = 1'b1; dma_addr = 9'd0; dma_data = 8'h55;
    model_write(8'h03);
    @(posedge clk); #1;
    sram_cs = 1'b0; sram_we = 1'b0; dma_strobe = 1'b0;
    rd(3'd3, v, v9); check("clr_strobe_cnt", v, 8'd0);
    rd(3'd0, v, v9); check("clr_strobe_status", v, 8'h08);

    // Short block: check value and block-counter wrap
    wr(8'h03);
    for (int i = 0; i < 9; i++) strobe(9'(i), digits[i]);
    idle();
    rd(3'd1, v, lo); rd(3'd2, v, hi);
    check("b9_crc", {hi, lo}, 16'h31C3);
    rd(3'd0, v, v9); check("b9_status", v9, 8'h0A);
    rd(3'd5, v, v9); check("b9_blocks1", v9, 8'd1);
    rd(3'd3, v, v9); check("b9_cnt", v9, 8'd9);
    for (int b = 0; b < 254; b++)
      for (int i = 0; i < 9; i++) strobe(9'(i), digits[i]);
    idle();
    rd(3'd5, v, v9); check("b9_blocks255", v9, 8'd255);
    for (int i = 0; i < 9; i++) strobe(9'(i), digits[i]);
    idle();
    rd(3'd5, v, v9); check("b9_blocks_wrap", v9, 8'd0);

    // Reset in the middle of a block
    wr(8'h03);
    stream(0, 99, 8'h00, 1'b1);
    rd(3'd3, v, v9); check("pre_rst_cnt", v, 8'd100);
    strobe(9'd100, 8'h77);
    @(posedge clk); #1;
    dma_strobe = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_d_out", d_out, 8'h00);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v, v9);
      check($sformatf("rst_reg%0d", a), v, 8'h00);
    end

    // Randomized traffic against the model
    wr(8'h02);
    for (int it = 0; it < 8000; it++) begin
      int r;
      logic [2:0] ra;
      r = $urandom_range(0, 999);
      if (r < 2) begin
        wr({6'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0)});
      end else if (r < 30) begin
        ra = 3'($urandom_range(0, 7));
        rd(ra, v, v9);
        check($sformatf("rand_reg%0d", ra), v, model_reg(ra));
      end else if (r < 32) begin
        strobe(9'($urandom_range(0, 511)), 8'($urandom));
      end else begin
        strobe(m_busy ? 9'(q.size()) : 9'd0, 8'($urandom));
      end
    end
    idle();
    for (int a = 0; a < 6; a++) begin
      rd(3'(a), v, v9);
      check($sformatf("final_reg%0d", a), v, model_reg(3'(a)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
